// File: rtl/segment_transition_ctl.sv
// Segment transition controller: arms a read-segment switch on UPDATE and takes it
// on the selected trigger (index wrap, system time, GPIO, external toggle or immediate).
module segment_transition_ctl #(
  parameter logic [15:0] REP_INFINITE = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        UPDATE,
  input  logic        REQ_RD_SEGMENT,
  input  logic [7:0]  TRANSITION_MODE,
  input  logic [63:0] TRANSITION_VALUE,
  input  logic [15:0] REP0,
  input  logic [15:0] REP1,
  input  logic [63:0] SYS_TIME,
  input  logic [3:0]  GPIO_IN,
  input  logic        IDX_WRAP,
  output logic        SEGMENT,
  output logic        STOP,
  output logic        PENDING,
  output logic [15:0] LOOP_CNT
);

  localparam logic [7:0] MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0] MODE_GPIO      = 8'h02;
  localparam logic [7:0] MODE_EXT       = 8'h03;
  localparam logic [7:0] MODE_IMMEDIATE = 8'hFF;

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, EXT_RUN} state_t;

  state_t      state_q, state_d;
  logic        seg_sh_q, seg_sh_d;
  logic [7:0]  mode_q, mode_d;
  logic [63:0] val_q, val_d;
  logic [15:0] rep0_q, rep0_d;
  logic [15:0] rep1_q, rep1_d;
  logic        ext_q, ext_d;
  logic        segment_q, segment_d;
  logic        stop_q, stop_d;
  logic [15:0] loop_cnt_q, loop_cnt_d;
  logic        mode_ok, trig;
  logic [16:0] wrap_res;

  // Returns {stop, loop_cnt} after one wrap; count saturates, stop holds the count.
  function automatic logic [16:0] wrap_count(input logic [15:0] cnt, input logic stop,
                                             input logic [15:0] rep);
    logic [16:0] inc;
    logic [15:0] sat;
    inc = {1'b0, cnt} + 17'd1;
    sat = inc[16] ? 16'hFFFF : inc[15:0];
    if (stop) return {1'b1, cnt};
    return {(rep != REP_INFINITE) && (inc == ({1'b0, rep} + 17'd1)), sat};
  endfunction

  always_comb begin
    mode_ok = (TRANSITION_MODE == MODE_SYNC_IDX) || (TRANSITION_MODE == MODE_SYS_TIME) ||
              (TRANSITION_MODE == MODE_GPIO) || (TRANSITION_MODE == MODE_EXT) ||
              (TRANSITION_MODE == MODE_IMMEDIATE);
    case (mode_q)
      MODE_SYNC_IDX, MODE_EXT: trig = IDX_WRAP;
      MODE_SYS_TIME:           trig = (SYS_TIME >= val_q);
      MODE_GPIO:               trig = GPIO_IN[val_q[1:0]];
      default:                 trig = 1'b0;
    endcase
    wrap_res = wrap_count(loop_cnt_q, stop_q, segment_q ? rep1_q : rep0_q);
  end

  always_comb begin
    state_d    = state_q;
    seg_sh_d   = seg_sh_q;
    mode_d     = mode_q;
    val_d      = val_q;
    rep0_d     = rep0_q;
    rep1_d     = rep1_q;
    ext_d      = ext_q;
    segment_d  = segment_q;
    stop_d     = stop_q;
    loop_cnt_d = loop_cnt_q;
    if (UPDATE && mode_ok) begin
      seg_sh_d = REQ_RD_SEGMENT;
      mode_d   = TRANSITION_MODE;
      val_d    = TRANSITION_VALUE;
      rep0_d   = REP0;
      rep1_d   = REP1;
      if (TRANSITION_MODE == MODE_IMMEDIATE) begin
        state_d    = IDLE;
        ext_d      = 1'b0;
        segment_d  = REQ_RD_SEGMENT;
        stop_d     = 1'b0;
        loop_cnt_d = '0;
      end else begin
        state_d = WAIT_TRIG;
        ext_d   = (TRANSITION_MODE == MODE_EXT);
        // The active segment keeps counting its wraps until the new request fires.
        if (IDX_WRAP && state_q != EXT_RUN) begin
          stop_d     = wrap_res[16];
          loop_cnt_d = wrap_res[15:0];
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (IDX_WRAP) begin
            stop_d     = wrap_res[16];
            loop_cnt_d = wrap_res[15:0];
          end
        end
        WAIT_TRIG: begin
          if (trig) begin
            state_d    = ext_q ? EXT_RUN : IDLE;
            segment_d  = seg_sh_q;
            stop_d     = 1'b0;
            loop_cnt_d = '0;
          end else if (IDX_WRAP) begin
            stop_d     = wrap_res[16];
            loop_cnt_d = wrap_res[15:0];
          end
        end
        EXT_RUN: begin
          if (IDX_WRAP) begin
            segment_d  = ~segment_q;
            loop_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      seg_sh_q   <= 1'b0;
      mode_q     <= '0;
      val_q      <= '0;
      rep0_q     <= '0;
      rep1_q     <= '0;
      ext_q      <= 1'b0;
      segment_q  <= 1'b0;
      stop_q     <= 1'b0;
      loop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      seg_sh_q   <= seg_sh_d;
      mode_q     <= mode_d;
      val_q      <= val_d;
      rep0_q     <= rep0_d;
      rep1_q     <= rep1_d;
      ext_q      <= ext_d;
      segment_q  <= segment_d;
      stop_q     <= stop_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

  assign SEGMENT  = segment_q;
  assign STOP     = stop_q;
  assign PENDING  = (state_q == WAIT_TRIG);
  assign LOOP_CNT = loop_cnt_q;

endmodule
